sys_bus_arbiter: RTL
====================

Name: sys_bus_arbiter

Overview:
- Shares the single system bus slave port between three masters: m0 = JTAG debug, m1 = core data access (mem stage), m2 = core instruction fetch.
- Registered grant with per-transaction lock, fixed priority plus a starvation guard for fetch, and a slave-timeout error return.
- Produces the wait/halt requests consumed by the pipeline hold controller.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 8, consecutive lost arbitrations before m2 is promoted above m1; range 1..255.
- TIMEOUT, 64, BUSY cycles without slave ack before error return; 0 disables; range 0..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- mN_req_i  in  1  master N request (N=0,1,2); held until mN_ack_o
- mN_we_i  in  1  master N write enable
- mN_addr_i  in  ADDR_W  master N address
- mN_wdata_i  in  DATA_W  master N write data
- mN_rdata_o  out  DATA_W  read data, valid while mN_ack_o
- mN_ack_o  out  1  one-cycle completion pulse
- mN_err_o  out  1  timeout error, valid with mN_ack_o
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  ADDR_W  slave address
- s_wdata_o  out  DATA_W  slave write data
- s_rdata_i  in  DATA_W  slave read data
- s_ack_i  in  1  slave completion; may be combinational in the same cycle as s_req_o
- mem_wait_req_o  out  1  = m1_req_i & ~m1_ack_o; drives the mem-stage wait request to ctrl
- if_wait_req_o  out  1  = m2_req_i & ~m2_ack_o; stalls the fetch/pc stage
- jtag_busy_o  out  1  high while m0 owns the bus (state BUSY)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, owner=0, starve_cnt=0, to_cnt=0.
  - s_req_o=0, s_we_o=0, s_addr_o=0, s_wdata_o=0.
  - All mN_ack_o, mN_err_o, mN_rdata_o and jtag_busy_o = 0.
  - Reset mid-transaction abandons it; no ack is issued.
- State machine: IDLE and BUSY.
- IDLE, any request present:
  - Winner is m0 if m0_req_i.
  - Otherwise m2 if m2_req_i and starve_cnt >= STARVE_MAX.
  - Otherwise m1 if m1_req_i, else m2.
  - On the clock edge: owner <= winner, and the winner's we/addr/wdata are latched into the s_* registers. Go to BUSY, to_cnt <= 0.
  - No request: stay in IDLE.
- BUSY:
  - s_req_o=1, driven from the latched registers. Master inputs are ignored until return to IDLE.
  - s_ack_i=1: m[owner]_ack_o=1 and m[owner]_rdata_o=s_rdata_i, both combinational that cycle. Next edge: IDLE, s_req_o<=0.
  - No ack: to_cnt increments.
  - TIMEOUT!=0 and to_cnt==TIMEOUT-1 with no ack: m[owner]_ack_o=1, m[owner]_err_o=1, rdata=0 that cycle, then return to IDLE. A late s_ack_i arriving in IDLE is ignored.
- Latency:
  - Request seen in IDLE at cycle 0; s_req_o high at cycle 1; earliest ack at cycle 1.
  - At least one IDLE cycle between transactions, so a master that drops req after its ack is never double-issued.
- starve_cnt updates only on IDLE arbitration edges:
  - +1, saturating at 255, when m2_req_i and m2 loses.
  - Cleared when m2 wins, or when m2_req_i=0 at arbitration.
- Non-owner masters: ack=0, err=0, rdata=0 at all times.
- Simultaneous events: m0 always wins, even against a promoted m2; starve_cnt still increments.

Test Plan:
- Single read: m1 read addr 0x1000; slave acks in its first cycle with 0xDEADBEEF -> s_req_o high at cycle 1 only; m1_ack_o pulse with rdata 0xDEADBEEF at cycle 1; mem_wait_req_o high at cycle 0 only.
- Contention: m0, m1, m2 all request at cycle 0; slave acks immediately; each master drops req after its ack -> grants in order m0, m1, m2; each s_req_o pulse separated by one IDLE cycle; jtag_busy_o high only during the m0 BUSY cycle.
- Starvation: m1 requests continuously; m2 requests continuously; STARVE_MAX=8 -> m2 granted at the 9th arbitration; starve_cnt then reads 0.
- Timeout: TIMEOUT=4; m2 fetch with s_ack_i tied 0 -> m2_ack_o and m2_err_o pulse in the 4th BUSY cycle; rdata=0; returns to IDLE; next request is served normally.
- Write latch: m1 write addr 0x2000, data 0x55; m1 changes addr to 0x3000 mid-BUSY; slave acks after 3 cycles -> s_addr_o stays 0x2000 and s_wdata_o stays 0x55 throughout.
- Reset mid-op: assert rst during BUSY -> s_req_o=0 and all acks=0 immediately (asynchronous); after release, state is IDLE and starve_cnt=0.

Source files
------------

// File: rtl/sys_bus_arbiter.sv
// System bus arbiter: JTAG (m0), core data (m1) and core fetch (m2) share one slave port.
// The grant is registered and held for the whole transaction. Fetch gets a starvation guard and there is a slave timeout.
module sys_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    input  logic              m2_req_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    input  logic [DATA_W-1:0] m2_wdata_i,
    output logic [DATA_W-1:0] m2_rdata_o,
    output logic              m2_ack_o,
    output logic              m2_err_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic              s_ack_i,
    output logic              mem_wait_req_o,
    output logic              if_wait_req_o,
    output logic              jtag_busy_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    state_t            state, state_nxt;
    logic [1:0]        owner, winner;
    logic [7:0]        starve_cnt, to_cnt;
    bus_req_t          s_reg, win_req;
    logic              any_req, busy, timeout_hit, done;
    logic [2:0]        ack_vec;
    logic [DATA_W-1:0] rd_val;

    assign any_req = m0_req_i | m1_req_i | m2_req_i;
    assign busy    = (state == BUSY);

    // m0 always wins; a starved m2 is promoted only above m1.
    always_comb begin
        winner  = 2'd2;
        win_req = {m2_we_i, m2_addr_i, m2_wdata_i};
        if (m0_req_i) begin
            winner  = 2'd0;
            win_req = {m0_we_i, m0_addr_i, m0_wdata_i};
        end else if (m2_req_i && (starve_cnt >= 8'(STARVE_MAX))) begin
            winner  = 2'd2;
            win_req = {m2_we_i, m2_addr_i, m2_wdata_i};
        end else if (m1_req_i) begin
            winner  = 2'd1;
            win_req = {m1_we_i, m1_addr_i, m1_wdata_i};
        end
    end

    assign timeout_hit = busy && (TIMEOUT != 0) && !s_ack_i && (to_cnt == 8'(TIMEOUT - 1));
    assign done        = busy && (s_ack_i || timeout_hit);
    assign ack_vec     = done ? (3'b001 << owner) : 3'b000;
    assign rd_val      = (busy && s_ack_i) ? s_rdata_i : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 2'd0;
            starve_cnt <= 8'd0;
            to_cnt     <= 8'd0;
            s_reg      <= '0;
        end else if (!busy && any_req) begin
            owner  <= winner;
            s_reg  <= win_req;
            to_cnt <= 8'd0;
            if (winner == 2'd2 || !m2_req_i)
                starve_cnt <= 8'd0;
            else if (starve_cnt != 8'hFF)
                starve_cnt <= starve_cnt + 8'd1;
        end else if (busy && !s_ack_i) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    assign s_req_o   = busy;
    assign s_we_o    = s_reg.we;
    assign s_addr_o  = s_reg.addr;
    assign s_wdata_o = s_reg.wdata;

    assign m0_ack_o   = ack_vec[0];
    assign m1_ack_o   = ack_vec[1];
    assign m2_ack_o   = ack_vec[2];
    assign m0_err_o   = ack_vec[0] & timeout_hit;
    assign m1_err_o   = ack_vec[1] & timeout_hit;
    assign m2_err_o   = ack_vec[2] & timeout_hit;
    assign m0_rdata_o = ack_vec[0] ? rd_val : '0;
    assign m1_rdata_o = ack_vec[1] ? rd_val : '0;
    assign m2_rdata_o = ack_vec[2] ? rd_val : '0;

    assign mem_wait_req_o = m1_req_i & ~m1_ack_o;
    assign if_wait_req_o  = m2_req_i & ~m2_ack_o;
    assign jtag_busy_o    = busy && (owner == 2'd0);

endmodule
